// File: rtl/cache_dual_ctrl_if.sv
// Bus bundle for cache_dual_ctrl: the core-side request/response handshake,
// the shared SRAM command port, both SRAM read-data copies and the mismatch count.
//   slave  : controller view (drives Req_Ready, Rsp_*, SRAM command, MisCnt)
//   master : environment view (core + duplicated SRAM pair)
interface cache_dual_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned CNT_WIDTH  = 8
) ();
  // Core request
  logic                  Req_Valid_SI;
  logic                  Req_Ready_SO;
  logic                  Req_WrEn_SI;
  logic [7:0]            Req_BEn_SI;
  logic [63:0]           Req_WrData_DI;
  logic [ADDR_WIDTH-1:0] Req_Addr_DI;
  // Core response
  logic                  Rsp_Valid_SO;
  logic                  Rsp_Ready_SI;
  logic [63:0]           Rsp_RdData_DO;
  logic                  Rsp_Err_SO;
  // Shared SRAM command
  logic                  CSel_SO;
  logic                  WrEn_SO;
  logic [7:0]            BEn_SO;
  logic [63:0]           WrData_DO;
  logic [ADDR_WIDTH-1:0] Addr_DO;
  // Per-copy read data
  logic [63:0]           RdData_DI_1;
  logic [63:0]           RdData_DI_2;
  // Redundancy status
  logic [CNT_WIDTH-1:0]  MisCnt_DO;

  modport slave (
    input  Req_Valid_SI, Req_WrEn_SI, Req_BEn_SI, Req_WrData_DI, Req_Addr_DI,
    input  Rsp_Ready_SI, RdData_DI_1, RdData_DI_2,
    output Req_Ready_SO, Rsp_Valid_SO, Rsp_RdData_DO, Rsp_Err_SO,
    output CSel_SO, WrEn_SO, BEn_SO, WrData_DO, Addr_DO, MisCnt_DO
  );

  modport master (
    output Req_Valid_SI, Req_WrEn_SI, Req_BEn_SI, Req_WrData_DI, Req_Addr_DI,
    output Rsp_Ready_SI, RdData_DI_1, RdData_DI_2,
    input  Req_Ready_SO, Rsp_Valid_SO, Rsp_RdData_DO, Rsp_Err_SO,
    input  CSel_SO, WrEn_SO, BEn_SO, WrData_DO, Addr_DO, MisCnt_DO
  );
endinterface

// File: rtl/cache_dual_ctrl.sv
// Single-outstanding request/response front-end for a duplicated 64-bit SRAM pair.
// One accepted request drives the shared SRAM command for one cycle, waits the
// read latency (OUT_REGS+1 cycles), captures both copies, returns copy 1 and
// flags/counts copy disagreement. Illegal addresses are answered with an error
// and never reach the SRAM.
// Ports:
//   Clk_CI, Rst_RBI : clock, asynchronous active-low reset
//   bus             : cache_dual_ctrl_if.slave (request, response, SRAM, MisCnt)
//   Err_Clr_SI, Err_Sticky_SO : only with CACHE_ERR_STICKY_EN defined; sticky
//                     read-mismatch flag and its clear pulse
module cache_dual_ctrl #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_DEPTH = 128,
  parameter int unsigned OUT_REGS   = 0,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic Clk_CI,
  input  logic Rst_RBI,
`ifdef CACHE_ERR_STICKY_EN
  input  logic Err_Clr_SI,
  output logic Err_Sticky_SO,
`endif
  cache_dual_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic                  csel_q, csel_d;
  logic                  wr_en_q, wr_en_d;
  logic [7:0]            ben_q, ben_d;
  logic [63:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wait_q, wait_d;
  logic [63:0]           rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [CNT_WIDTH-1:0]  mis_cnt_q, mis_cnt_d;

  logic accept, addr_ok, mismatch, capture;

  assign accept   = bus.Req_Valid_SI && (state_q == StIdle);
  assign addr_ok  = 32'(bus.Req_Addr_DI) < DATA_DEPTH;
  assign mismatch = bus.RdData_DI_1 != bus.RdData_DI_2;
  // Last WAIT cycle: read data of both copies is valid at this edge.
  assign capture  = (state_q == StWait) && !wait_q;

  always_comb begin
    state_d    = state_q;
    csel_d     = 1'b0;
    wr_en_d    = wr_en_q;
    ben_d      = ben_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    wait_d     = wait_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    mis_cnt_d  = mis_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (addr_ok) begin
            state_d = StIssue;
            csel_d  = 1'b1;
            wr_en_d = bus.Req_WrEn_SI;
            ben_d   = bus.Req_BEn_SI;
            wdata_d = bus.Req_WrData_DI;
            addr_d  = bus.Req_Addr_DI;
          end else begin
            state_d    = StResp;
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end
        end
      end
      StIssue: begin
        state_d = StWait;
        wait_d  = 1'(OUT_REGS);
      end
      StWait: begin
        if (!capture) begin
          wait_d = 1'b0;
        end else begin
          state_d = StResp;
          if (wr_en_q) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b0;
          end else begin
            rsp_data_d = bus.RdData_DI_1;
            rsp_err_d  = mismatch;
            if (mismatch && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      StResp: begin
        if (bus.Rsp_Ready_SI) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q    <= StIdle;
      csel_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      ben_q      <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      wait_q     <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      mis_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      csel_q     <= csel_d;
      wr_en_q    <= wr_en_d;
      ben_q      <= ben_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      wait_q     <= wait_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      mis_cnt_q  <= mis_cnt_d;
    end
  end

  assign bus.Req_Ready_SO  = (state_q == StIdle);
  assign bus.Rsp_Valid_SO  = (state_q == StResp);
  assign bus.Rsp_RdData_DO = rsp_data_q;
  assign bus.Rsp_Err_SO    = rsp_err_q;
  assign bus.CSel_SO       = csel_q;
  assign bus.WrEn_SO       = wr_en_q;
  assign bus.BEn_SO        = ben_q;
  assign bus.WrData_DO     = wdata_q;
  assign bus.Addr_DO       = addr_q;
  assign bus.MisCnt_DO     = mis_cnt_q;

`ifdef CACHE_ERR_STICKY_EN
  logic sticky_q, sticky_d;

  // Set has priority over clear so a mismatch coinciding with a clear is kept.
  always_comb begin
    sticky_d = sticky_q;
    if (Err_Clr_SI) sticky_d = 1'b0;
    if (capture && !wr_en_q && mismatch) sticky_d = 1'b1;
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) sticky_q <= 1'b0;
    else          sticky_q <= sticky_d;
  end

  assign Err_Sticky_SO = sticky_q;
`endif

endmodule

// File: tb/tb_cache_dual_ctrl.sv
module tb_cache_dual_ctrl;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned CW    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_dual_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) if0 ();
  cache_dual_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) if1 ();

`ifdef CACHE_ERR_STICKY_EN
  logic err_clr0 = 1'b0;
  logic err_clr1 = 1'b0;
  logic sticky0, sticky1;
`endif

  cache_dual_ctrl #(.ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH), .OUT_REGS(0), .CNT_WIDTH(CW)) u_dut0 (
    .Clk_CI (clk),
    .Rst_RBI(rst_n),
`ifdef CACHE_ERR_STICKY_EN
    .Err_Clr_SI   (err_clr0),
    .Err_Sticky_SO(sticky0),
`endif
    .bus    (if0)
  );

  cache_dual_ctrl #(.ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH), .OUT_REGS(1), .CNT_WIDTH(CW)) u_dut1 (
    .Clk_CI (clk),
    .Rst_RBI(rst_n),
`ifdef CACHE_ERR_STICKY_EN
    .Err_Clr_SI   (err_clr1),
    .Err_Sticky_SO(sticky1),
`endif
    .bus    (if1)
  );

  // SRAM pair model for dut0 (no output register); copy 2 = copy 1 ^ flip0.
  logic [63:0] mem0 [256];
  logic [63:0] rd0;
  logic [63:0] flip0 = 64'h0;
  always_ff @(posedge clk) begin
    if (if0.CSel_SO) begin
      if (if0.WrEn_SO) begin
        for (int b = 0; b < 8; b++)
          if (if0.BEn_SO[b]) mem0[if0.Addr_DO][8*b +: 8] <= if0.WrData_DO[8*b +: 8];
      end else begin
        rd0 <= mem0[if0.Addr_DO];
      end
    end
  end
  assign if0.RdData_DI_1 = rd0;
  assign if0.RdData_DI_2 = rd0 ^ flip0;

  // Read-only pattern SRAM for dut1 with one output-register stage.
  logic [63:0] rd1_a, rd1_b;
  always_ff @(posedge clk) begin
    if (if1.CSel_SO) rd1_a <= {56'hA5A5_0000_0000_00, if1.Addr_DO};
    rd1_b <= rd1_a;
  end
  assign if1.RdData_DI_1 = rd1_b;
  assign if1.RdData_DI_2 = rd1_b;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } rsp_t;

  rsp_t        sb[$];
  logic [63:0] shadow [256];
  int          exp_mis = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // One transaction on dut0. hold>0: keep Rsp_Ready low that many cycles of valid;
  // hold<0: Rsp_Ready already high from the accept onward.
  task automatic txn0(input logic we, input logic [7:0] ben, input logic [63:0] wd,
                      input logic [7:0] addr, input int hold, input string tag);
    rsp_t e;
    int   lat, csel_cnt;
    bit   illegal;
    illegal = (int'(addr) >= int'(DEPTH));
    if (illegal) begin
      e.data = '0;
      e.err  = 1'b1;
    end else if (we) begin
      e.data = '0;
      e.err  = 1'b0;
      for (int b = 0; b < 8; b++) if (ben[b]) shadow[addr][8*b +: 8] = wd[8*b +: 8];
    end else begin
      e.data = shadow[addr];
      e.err  = (flip0 != 64'h0);
      if (e.err) exp_mis = (exp_mis == 255) ? 255 : exp_mis + 1;
    end
    sb.push_back(e);

    @(negedge clk);
    chk($sformatf("%s req_ready", tag), 64'(if0.Req_Ready_SO), 64'd1);
    if0.Req_Valid_SI  = 1'b1;
    if0.Req_WrEn_SI   = we;
    if0.Req_BEn_SI    = ben;
    if0.Req_WrData_DI = wd;
    if0.Req_Addr_DI   = addr;
    if0.Rsp_Ready_SI  = (hold < 0);
    @(posedge clk);
    #1 if0.Req_Valid_SI = 1'b0;

    lat = 0;
    csel_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (if0.CSel_SO) csel_cnt++;
      if (if0.Rsp_Valid_SO) begin
        lat = k;
        break;
      end
    end
    e = sb.pop_front();
    chk($sformatf("%s latency", tag), 64'(lat), illegal ? 64'd1 : 64'd3);
    chk($sformatf("%s csel_pulses", tag), 64'(csel_cnt), illegal ? 64'd0 : 64'd1);
    chk($sformatf("%s rdata", tag), if0.Rsp_RdData_DO, e.data);
    chk($sformatf("%s err", tag), 64'(if0.Rsp_Err_SO), 64'(e.err));
    chk($sformatf("%s miscnt", tag), 64'(if0.MisCnt_DO), 64'(exp_mis));

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk($sformatf("%s hold%0d valid", tag, h), 64'(if0.Rsp_Valid_SO), 64'd1);
      chk($sformatf("%s hold%0d rdata", tag, h), if0.Rsp_RdData_DO, e.data);
      chk($sformatf("%s hold%0d err", tag, h), 64'(if0.Rsp_Err_SO), 64'(e.err));
      chk($sformatf("%s hold%0d req_ready", tag, h), 64'(if0.Req_Ready_SO), 64'd0);
    end
    if0.Rsp_Ready_SI = 1'b1;
    @(posedge clk);
    #1 if0.Rsp_Ready_SI = 1'b0;
    @(negedge clk);
    chk($sformatf("%s valid_drop", tag), 64'(if0.Rsp_Valid_SO), 64'd0);
    chk($sformatf("%s idle", tag), 64'(if0.Req_Ready_SO), 64'd1);
  endtask

  task automatic chk_reset0(input string tag);
    chk($sformatf("%s req_ready", tag), 64'(if0.Req_Ready_SO), 64'd1);
    chk($sformatf("%s rsp_valid", tag), 64'(if0.Rsp_Valid_SO), 64'd0);
    chk($sformatf("%s rsp_rdata", tag), if0.Rsp_RdData_DO, 64'd0);
    chk($sformatf("%s rsp_err", tag), 64'(if0.Rsp_Err_SO), 64'd0);
    chk($sformatf("%s csel", tag), 64'(if0.CSel_SO), 64'd0);
    chk($sformatf("%s wren", tag), 64'(if0.WrEn_SO), 64'd0);
    chk($sformatf("%s ben", tag), 64'(if0.BEn_SO), 64'd0);
    chk($sformatf("%s wdata", tag), if0.WrData_DO, 64'd0);
    chk($sformatf("%s addr", tag), 64'(if0.Addr_DO), 64'd0);
    chk($sformatf("%s miscnt", tag), 64'(if0.MisCnt_DO), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    int lat;
    if0.Req_Valid_SI = 1'b0; if0.Req_WrEn_SI = 1'b0; if0.Req_BEn_SI = '0;
    if0.Req_WrData_DI = '0;  if0.Req_Addr_DI = '0;   if0.Rsp_Ready_SI = 1'b0;
    if1.Req_Valid_SI = 1'b0; if1.Req_WrEn_SI = 1'b0; if1.Req_BEn_SI = '0;
    if1.Req_WrData_DI = '0;  if1.Req_Addr_DI = '0;   if1.Rsp_Ready_SI = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset0("reset");
    chk("reset dut1 req_ready", 64'(if1.Req_Ready_SO), 64'd1);
    chk("reset dut1 csel", 64'(if1.CSel_SO), 64'd0);

    // Basic write/read, then mismatching read.
    txn0(1'b1, 8'hFF, 64'h0123456789ABCDEF, 8'd5, 0, "wr5");
    txn0(1'b0, 8'h00, 64'h0, 8'd5, 0, "rd5");
    txn0(1'b1, 8'hFF, 64'hDEADBEEF00C0FFEE, 8'd9, 0, "wr9");
    flip0 = 64'h1;
    txn0(1'b0, 8'h00, 64'h0, 8'd9, 0, "rd9_mismatch");
    flip0 = 64'h0;
`ifdef CACHE_ERR_STICKY_EN
    chk("sticky set", 64'(sticky0), 64'd1);
    txn0(1'b0, 8'h00, 64'h0, 8'd5, 0, "rd5_clean");
    chk("sticky held", 64'(sticky0), 64'd1);
    @(negedge clk) err_clr0 = 1'b1;
    @(negedge clk) err_clr0 = 1'b0;
    chk("sticky cleared", 64'(sticky0), 64'd0);
`endif

    // Illegal address: no SRAM access, error response.
    txn0(1'b0, 8'h00, 64'h0, 8'd200, 0, "rd200_illegal");
`ifdef CACHE_ERR_STICKY_EN
    chk("sticky illegal", 64'(sticky0), 64'd0);
`endif

    // Back-pressure, zero-byte-enable write, early response ready.
    txn0(1'b0, 8'h00, 64'h0, 8'd5, 5, "rd5_hold");
    txn0(1'b1, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 8'd5, 0, "wr5_ben0");
    txn0(1'b0, 8'h00, 64'h0, 8'd5, -1, "rd5_early_ready");
    txn0(1'b1, 8'h0F, 64'h1111_2222_3333_4444, 8'd5, 0, "wr5_partial");
    txn0(1'b0, 8'h00, 64'h0, 8'd5, 0, "rd5_partial");

    // Mismatch counter saturation.
    flip0 = 64'h8000_0000_0000_0000;
    for (int i = 0; i < 300; i++) txn0(1'b0, 8'h00, 64'h0, 8'd5, 0, "sat");
    flip0 = 64'h0;
    chk("miscnt saturated", 64'(if0.MisCnt_DO), 64'd255);

    // Reset during WAIT of a dut0 read.
    @(negedge clk);
    if0.Req_Valid_SI = 1'b1; if0.Req_WrEn_SI = 1'b0; if0.Req_Addr_DI = 8'd5;
    @(posedge clk);
    #1 if0.Req_Valid_SI = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset0("abort0");
    exp_mis = 0;
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (if0.Rsp_Valid_SO || if0.CSel_SO) seen++;
    end
    chk("abort0 no_response", 64'(seen), 64'd0);

    // Reset during the second WAIT cycle of a dut1 (OUT_REGS=1) read.
    @(negedge clk);
    if1.Req_Valid_SI = 1'b1; if1.Req_WrEn_SI = 1'b0; if1.Req_Addr_DI = 8'd3;
    @(posedge clk);
    #1 if1.Req_Valid_SI = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort1 rsp_valid", 64'(if1.Rsp_Valid_SO), 64'd0);
    chk("abort1 csel", 64'(if1.CSel_SO), 64'd0);
    chk("abort1 req_ready", 64'(if1.Req_Ready_SO), 64'd1);
    chk("abort1 rsp_rdata", if1.Rsp_RdData_DO, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (if1.Rsp_Valid_SO) seen++;
    end
    chk("abort1 no_response", 64'(seen), 64'd0);

    // Full dut1 read: one extra cycle of latency.
    @(negedge clk);
    if1.Req_Valid_SI = 1'b1; if1.Req_WrEn_SI = 1'b0; if1.Req_Addr_DI = 8'd3;
    @(posedge clk);
    #1 if1.Req_Valid_SI = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (if1.Rsp_Valid_SO) begin
        lat = k;
        break;
      end
    end
    chk("dut1 latency", 64'(lat), 64'd4);
    chk("dut1 rdata", if1.Rsp_RdData_DO, 64'hA5A5_0000_0000_0003);
    chk("dut1 err", 64'(if1.Rsp_Err_SO), 64'd0);
    if1.Rsp_Ready_SI = 1'b1;
    @(posedge clk);
    #1 if1.Rsp_Ready_SI = 1'b0;
    @(negedge clk);
    chk("dut1 valid_drop", 64'(if1.Rsp_Valid_SO), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cache_dual_ctrl.md
Name: cache_dual_ctrl

Overview:
- Request/response front-end that sits directly upstream of the duplicated 64-bit SRAM pair (two identical arrays sharing one command port, each with its own read data).
- Accepts one request at a time from a core-side valid/ready port and drives the shared SRAM command for exactly one cycle.
- Waits the SRAM read latency, captures both read words and returns copy 1 on the response port.
- Flags any copy-1/copy-2 disagreement and counts mismatches for the redundancy check.

Parameters:
- ADDR_WIDTH, 7, SRAM word address width.
- DATA_DEPTH, 128, number of valid words; addresses >= DATA_DEPTH are illegal.
- OUT_REGS, 0, SRAM output-register stages (0 or 1); sets the wait length.
- CNT_WIDTH, 8, width of the mismatch counter.

Ports:
- Clk_CI  in  1  clock.
- Rst_RBI  in  1  asynchronous reset, active-low.
- Req_Valid_SI  in  1  request valid.
- Req_Ready_SO  out  1  request ready.
- Req_WrEn_SI  in  1  1=write, 0=read.
- Req_BEn_SI  in  8  byte enables for writes.
- Req_WrData_DI  in  64  write data.
- Req_Addr_DI  in  ADDR_WIDTH  word address.
- Rsp_Valid_SO  out  1  response valid.
- Rsp_Ready_SI  in  1  response ready.
- Rsp_RdData_DO  out  64  read data (copy 1); 0 for writes and errors.
- Rsp_Err_SO  out  1  copy mismatch or illegal address.
- CSel_SO  out  1  SRAM chip select.
- WrEn_SO  out  1  SRAM write enable.
- BEn_SO  out  8  SRAM byte enables.
- WrData_DO  out  64  SRAM write data.
- Addr_DO  out  ADDR_WIDTH  SRAM address.
- RdData_DI_1  in  64  read data, copy 1.
- RdData_DI_2  in  64  read data, copy 2.
- MisCnt_DO  out  CNT_WIDTH  saturating mismatch count.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all SRAM-side outputs 0.
  - Rsp_Valid_SO=0, Rsp_RdData_DO=0, Rsp_Err_SO=0, MisCnt_DO=0.
  - Req_Ready_SO=1 after release.
- Req_Ready_SO = (state==IDLE), combinational from state only.
- Accept occurs on an edge with Req_Valid_SI & Req_Ready_SO; the request is registered on that edge.
- FSM: IDLE, ISSUE, WAIT, RESP.
  - IDLE -> ISSUE on accept with legal address.
  - IDLE -> RESP on accept with Req_Addr_DI >= DATA_DEPTH: no SRAM access, CSel stays 0, Rsp_Err=1, RdData=0, MisCnt unchanged.
  - ISSUE, 1 cycle:
    - CSel_SO=1; WrEn/BEn/WrData/Addr carry the registered request.
    - All SRAM outputs are registered; CSel is 0 in every other state.
    - -> WAIT.
  - WAIT, OUT_REGS+1 cycles, tracked by a down-counter:
    - On the final WAIT edge of a read: Rsp_RdData <= RdData_DI_1; Rsp_Err <= (RdData_DI_1 != RdData_DI_2), full 64-bit compare.
    - On mismatch, MisCnt increments, saturating at all-ones.
    - Writes: Rsp_RdData=0, Rsp_Err=0, no compare.
    - -> RESP.
  - RESP:
    - Rsp_Valid_SO=1; data and err held stable until Rsp_Ready_SI is sampled high.
    - -> IDLE on that edge; Rsp_Valid low the next cycle.
- Latency with OUT_REGS=0:
  - accept edge E; CSel high in cycle E+1; capture at edge E+2; Rsp_Valid high from cycle E+3.
  - Each extra OUT_REGS stage adds 1 cycle.
- Throughput: at most one transaction per 4+OUT_REGS cycles; no accept/response overlap.
- Write with BEn=0x00 is still issued (CSel=1) and acknowledged with Err=0.
- Rsp_Ready_SI high before Rsp_Valid has no effect.
- Reset mid-transaction aborts it: CSel drops immediately, no response is produced, MisCnt clears.

Optional Feature:
- Macro: CACHE_ERR_STICKY_EN.
- With the macro defined:
  - Adds input Err_Clr_SI (1) and output Err_Sticky_SO (1), reset 0.
  - Err_Sticky sets on any read mismatch capture.
  - A single-cycle Err_Clr_SI pulse clears it.
  - Simultaneous set and clear leaves it set.
  - Illegal-address errors do not set it.
- Without the macro: both ports are absent and no sticky logic exists; everything else is identical.

Test Plan:
- Reset, then write addr 5, data 0x0123456789ABCDEF, BEn 0xFF; then read addr 5 with both copies returning that value.
  -> CSel pulses exactly 1 cycle per transaction; read response RdData=0x0123456789ABCDEF, Err=0; Rsp_Valid 3 cycles after the accept edge (OUT_REGS=0).
- Read addr 9 with RdData_DI_2 differing from copy 1 in bit 0.
  -> Err=1, RdData=copy 1, MisCnt 0->1; with CACHE_ERR_STICKY_EN, Err_Sticky=1 until an Err_Clr pulse.
- Read addr 200 with DATA_DEPTH=128.
  -> CSel never asserted, RESP with Err=1, RdData=0, MisCnt unchanged.
- Hold Rsp_Ready_SI low for 5 cycles during a response.
  -> Rsp_Valid/data/err stable for all 5 cycles, Req_Ready=0 throughout, IDLE one cycle after ready.
- 300 consecutive mismatching reads with CNT_WIDTH=8.
  -> MisCnt saturates at 255 and stays there.
- Assert Rst_RBI low during WAIT of a read; repeat with OUT_REGS=1.
  -> all outputs return to reset values asynchronously, no response is emitted; with OUT_REGS=1 Rsp_Valid appears at accept+4.
